if_stage_ctrl: RTL
==================

# if_stage_ctrl

Instruction-fetch stage and IF/ID pipeline register for the non-forwarding RV32I pipeline. It sits directly upstream of the hazard detection unit and consumes its `stall`, `flush` and `branch_taken` outputs. It owns the program counter, selects the next PC, and drives the instruction-memory address. It presents the registered instruction, PC and valid bit to the decode stage and hazard logic.

## Interface

Parameters:
- `XLEN`, 32, datapath and PC width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset

Ports:
- `clk`  in  1  pipeline clock
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold PC and IF/ID; driven by the hazard unit
- `flush`  in  1  kill the IF/ID contents (insert NOP)
- `branch_taken`  in  1  redirect PC to `alu_target`
- `alu_target`  in  XLEN  branch/jump target computed in EX
- `imem_addr`  out  XLEN  instruction-memory address (equals `pc`)
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`
- `pc`  out  XLEN  current fetch PC
- `IF_ID_pc`  out  XLEN  PC of the instruction in IF/ID
- `IF_ID_pc4`  out  XLEN  `IF_ID_pc + 4`, registered
- `IF_ID_instr`  out  32  instruction in IF/ID
- `IF_ID_valid`  out  1  IF/ID holds a real fetched instruction
- `misalign_err`  out  1  sticky flag: redirect target had `alu_target[1:0] != 0`
- `perf_stall_cycles`  out  32  present only with `FETCH_PERF_EN`
- `perf_flush_count`  out  32  present only with `FETCH_PERF_EN`

## Operation

- Reset values:
  - `pc = RESET_PC`
  - `IF_ID_instr = 32'h0000_0013` (NOP)
  - `IF_ID_pc = IF_ID_pc4 = 0`
  - `IF_ID_valid = 0`
  - `misalign_err = 0`
  - perf counters = 0
- FSM states: `BOOT`, `RUN`.
  - Reset enters `BOOT`.
  - `BOOT` lasts exactly one clock after `reset_n` rises. In that cycle IF/ID loads the fetch at `RESET_PC` (`valid = 1`) and PC goes to `RESET_PC + 4`. Control inputs are ignored.
  - The FSM then moves to `RUN` and never leaves it except through reset.
- Next-PC priority in `RUN`:
  1. `branch_taken`: PC becomes `{alu_target[XLEN-1:2], 2'b00}`.
  2. `stall`: PC holds.
  3. Otherwise PC becomes `pc + 4`.
- `misalign_err` sets when `branch_taken` occurs with `alu_target[1:0] != 0`. It clears only on reset.
- IF/ID priority in `RUN`:
  1. `flush`: load NOP with `valid = 0`; `IF_ID_pc` and `IF_ID_pc4` load 0.
  2. `stall`: hold all fields.
  3. Otherwise load `pc`, `pc + 4`, `imem_rdata`, `valid = 1`.
- `flush` and `stall` asserted together: `flush` wins for IF/ID.
- `branch_taken` and `stall` asserted together: `branch_taken` wins for PC.
- `flush` without `branch_taken`: kill IF/ID, and PC follows the stall / +4 rule.
- Arithmetic is modulo 2^XLEN: PC `32'hFFFF_FFFC` advances to `32'h0000_0000` with no flag.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight instruction is lost.

## Timing

- `imem_addr` is combinational from the PC register, so it changes in the same cycle as `pc`.
- Fetch-to-IF/ID latency is 1 clock.
- A redirect sampled at edge N:
  - The target appears on `pc` after edge N.
  - The target instruction is in IF/ID after edge N+1.
- Stall of K consecutive cycles: PC and IF/ID are frozen for exactly K edges. The next PC value is presented after the first non-stall edge.
- All outputs are registered except `imem_addr`.

## Configuration

- Macro `FETCH_PERF_EN`.
- Defined:
  - `perf_stall_cycles` increments on every `RUN` edge with `stall = 1` and `flush = 0`.
  - `perf_flush_count` increments on every `RUN` edge with `flush = 1`.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: both ports and all counter logic are absent. Fetch behaviour is identical.

## Structure

- Shared package `riscv_pipe_pkg` holds:
  - `NOP_INSTR` (32'h0000_0013)
  - opcode constants (JAL, JALR, B_TYPE, LOAD, …)
  - `if_id_t` struct {pc, pc4, instr, valid}
  - FSM enum `fetch_state_e`
- Sub-module `fetch_perf_counters` (saturating counter pair) is instantiated only under `FETCH_PERF_EN`.

## Test plan

- Reset release, `imem_rdata = 32'h00500093`, no hazards → edge 1: IF/ID {pc 0, instr 32'h00500093, valid 1}, `pc = 4`; edge 2: `pc = 8`.
- `stall = 1` for 2 cycles at `pc = 32'h10` → `pc` and IF/ID unchanged for 2 edges, then `pc = 32'h14`; with `FETCH_PERF_EN`, `perf_stall_cycles = 2`.
- `branch_taken = flush = 1`, `alu_target = 32'h40`, `stall = 1` → next edge: `pc = 32'h40`, `IF_ID_instr = 32'h13`, `IF_ID_valid = 0`; `perf_flush_count` increments by 1.
- `branch_taken = 1`, `alu_target = 32'h43` → `pc = 32'h40`, `misalign_err = 1`, which stays set through later traffic until reset.
- PC at `32'hFFFF_FFFC`, no hazards → `pc = 0`, `IF_ID_pc4 = 0`.
- `reset_n` dropped mid-stall with `pc = 32'h80` → `pc = RESET_PC` and `IF_ID_valid = 0` immediately, without waiting for a clock edge; FSM returns to `BOOT`.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared constants, IF/ID record and fetch FSM encoding for the RV32I pipeline
package riscv_pipe_pkg;
    localparam int PIPE_XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;

    typedef enum logic {BOOT, RUN} fetch_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc4;
        logic [31:0]          instr;
        logic                 valid;
    } if_id_t;
endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters: saturating stall-cycle and flush-event counters for the fetch stage
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    logic [31:0] stall_q, stall_d, flush_q, flush_d;

    always_comb begin
        stall_d = (stall_inc && stall_q != '1) ? stall_q + 32'd1 : stall_q;
        flush_d = (flush_inc && flush_q != '1) ? flush_q + 32'd1 : flush_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule

// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: PC register, next-PC select and IF/ID pipeline register.
// Define FETCH_PERF_EN to add the stall/flush performance counters.
module if_stage_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] alu_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_pc4,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid,
    output logic            misalign_err
`ifdef FETCH_PERF_EN
   ,output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count
`endif
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    if_id_t          if_id_q, if_id_d;
    logic            mis_q, mis_d;
    logic            run;

    assign run = state_q == RUN;

    // BOOT ignores hazard inputs; pc_q already equals RESET_PC there, so the plain fetch path is the boot fetch
    always_comb begin
        pc_plus4 = pc_q + XLEN'(4);
        state_d  = RUN;
        pc_d     = (run && branch_taken) ? {alu_target[XLEN-1:2], 2'b00} :
                   (run && stall)        ? pc_q : pc_plus4;
        mis_d    = mis_q | (run & branch_taken & (|alu_target[1:0]));
        if_id_d  = (run && flush) ? if_id_t'{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0} :
                   (run && stall) ? if_id_q :
                                    if_id_t'{pc: pc_q, pc4: pc_plus4, instr: imem_rdata, valid: 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            if_id_q <= if_id_t'{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign IF_ID_pc     = if_id_q.pc;
    assign IF_ID_pc4    = if_id_q.pc4;
    assign IF_ID_instr  = if_id_q.instr;
    assign IF_ID_valid  = if_id_q.valid;
    assign misalign_err = mis_q;

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_inc    (run & stall & ~flush),
        .flush_inc    (run & flush),
        .stall_cycles (perf_stall_cycles),
        .flush_count  (perf_flush_count)
    );
`endif
endmodule
